// File: rtl/audio_sd_dac.sv
// Output stage for the mixed audio stream: a click-free gain ramp toward mute
// or full volume, a gain-scaled sample for the digital (HDMI/I2S) path, and a
// first-order sigma-delta bitstream for the single-pin analog DAC.
module audio_sd_dac #(
  parameter int RAMP_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_3MHz_en,
  input  logic        clk_12KHz_en,
  input  logic        mute,
  input  logic [15:0] in,
  output logic [15:0] sample_out,
  output logic        dac_bit,
  output logic        muted
);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [9:0] STEP     = 10'(RAMP_STEP);
  localparam logic [8:0] GAIN_MAX = 9'd256;

  state_t      state_q, state_d;
  logic [8:0]  gain_q, gain_d;
  logic [15:0] sample_reg_q, sample_reg_d;
  logic [15:0] sample_out_q, sample_out_d;
  // Only the low 16 accumulator bits are kept here; the carry (acc[16]) is
  // exactly the registered dac_bit, so it lives in dac_bit_q.
  logic [15:0] acc_q;
  logic [16:0] acc_d;
  logic        dac_bit_q, dac_bit_d;
  logic        muted_q, muted_d;

  logic [9:0]  gain_up_sum;
  logic [8:0]  gain_up;
  logic [8:0]  gain_dn;

  logic signed [24:0] sample_ext;
  logic signed [24:0] gain_ext;
  logic signed [24:0] product;
  logic [15:0]        u;

  // Saturating candidate gains for one ramp tick in either direction; the
  // 10-bit sum keeps 256 + RAMP_STEP from wrapping before the clamp.
  always_comb begin
    gain_up_sum = {1'b0, gain_q} + STEP;
    gain_up     = (gain_up_sum > 10'(GAIN_MAX)) ? GAIN_MAX : gain_up_sum[8:0];
    gain_dn     = ({1'b0, gain_q} < STEP) ? 9'd0 : 9'(({1'b0, gain_q} - STEP));
  end

  // Ramp state machine and gain update; a tick always steps in the direction
  // of the current state, and a mute change only redirects from next cycle.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      MUTED: begin
        gain_d = 9'd0;
        if (!mute) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (clk_12KHz_en) gain_d = gain_up;
        if (mute) state_d = RAMP_DOWN;
        else if (clk_12KHz_en && (gain_up == GAIN_MAX)) state_d = PLAY;
      end
      PLAY: begin
        gain_d = GAIN_MAX;
        if (mute) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (clk_12KHz_en) gain_d = gain_dn;
        if (!mute) state_d = RAMP_UP;
        else if (clk_12KHz_en && (gain_dn == 9'd0)) state_d = MUTED;
      end
      default: begin
        state_d = MUTED;
        gain_d  = 9'd0;
      end
    endcase
  end

  // Sample capture, gain scaling and the sigma-delta modulator datapath.
  always_comb begin
    sample_reg_d = clk_3MHz_en ? in : sample_reg_q;
    sample_ext   = 25'(signed'(sample_reg_q));
    gain_ext     = 25'({1'b0, gain_q});
    product      = sample_ext * gain_ext;
    sample_out_d = 16'(product >>> 8);
    u            = {~sample_out_q[15], sample_out_q[14:0]};
    acc_d        = {1'b0, acc_q} + {1'b0, u};
    dac_bit_d    = acc_d[16];
    muted_d      = (state_d == MUTED);
  end

  // All state registers; reset wins over every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MUTED;
      gain_q       <= 9'd0;
      sample_reg_q <= 16'd0;
      sample_out_q <= 16'd0;
      acc_q        <= 16'd0;
      dac_bit_q    <= 1'b0;
      muted_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      sample_reg_q <= sample_reg_d;
      sample_out_q <= sample_out_d;
      acc_q        <= acc_d[15:0];
      dac_bit_q    <= dac_bit_d;
      muted_q      <= muted_d;
    end
  end

  assign sample_out = sample_out_q;
  assign dac_bit    = dac_bit_q;
  assign muted      = muted_q;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac: one instance with unit ramp step and one
// with a coarse step of 100. Gain is observed through sample_out by feeding
// in = 0x0100, which makes sample_out equal the gain one cycle later.
module tb_audio_sd_dac;

  logic        clk;
  logic        rst;
  logic        en3;
  logic [15:0] inSample;
  logic        mute1, tick1;
  logic        mute100, tick100;
  logic [15:0] out1, out100;
  logic        dac1, dac100;
  logic        muted1, muted100;

  int nAsserts;
  int nFails;
  int cnt;

  audio_sd_dac #(.RAMP_STEP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_3MHz_en  (en3),
    .clk_12KHz_en (tick1),
    .mute         (mute1),
    .in           (inSample),
    .sample_out   (out1),
    .dac_bit      (dac1),
    .muted        (muted1)
  );

  audio_sd_dac #(.RAMP_STEP(100)) dut100 (
    .clk          (clk),
    .rst          (rst),
    .clk_3MHz_en  (en3),
    .clk_12KHz_en (tick100),
    .mute         (mute100),
    .in           (inSample),
    .sample_out   (out100),
    .dac_bit      (dac100),
    .muted        (muted100)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instance's mute and tick for n cycles; ends on a negedge.
  task automatic applyStimulus(input bit sel, input logic m, input logic t, input int n);
    if (sel) mute100 = m; else mute1 = m;
    for (int i = 0; i < n; i++) begin
      if (sel) tick100 = t; else tick1 = t;
      @(negedge clk);
    end
    tick1   = 1'b0;
    tick100 = 1'b0;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Count dac_bit highs over n consecutive negedge samples.
  task automatic countDac(input bit sel, input int n, output int total);
    total = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total += sel ? int'(dac100) : int'(dac1);
    end
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;
    rst      = 1'b1;
    en3      = 1'b1;
    inSample = 16'h0100;
    mute1    = 1'b0;
    tick1    = 1'b0;
    mute100  = 1'b0;
    tick100  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_out1",    32'(out1), 32'h0);
    checkOutput("rst_dac1",    32'(dac1), 32'h0);
    checkOutput("rst_muted1",  32'(muted1), 32'h1);
    checkOutput("rst_muted100", 32'(muted100), 32'h1);

    // Release: muted still high until the first edge, then RAMP_UP
    rst = 1'b0;
    checkOutput("rel_muted_before", 32'(muted1), 32'h1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rel_muted_after", 32'(muted1), 32'h0);

    // Coarse step instance: 100, 200, 256 saturated
    applyStimulus(1, 0, 1, 1);
    applyStimulus(1, 0, 0, 2);
    checkOutput("s100_up1", 32'(out100), 32'd100);
    applyStimulus(1, 0, 1, 1);
    applyStimulus(1, 0, 0, 2);
    checkOutput("s100_up2", 32'(out100), 32'd200);
    applyStimulus(1, 0, 1, 1);
    applyStimulus(1, 0, 0, 2);
    checkOutput("s100_up3_sat", 32'(out100), 32'd256);
    // Down: 156, 56, 0 then MUTED
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 1, 0, 2);
    checkOutput("s100_dn1", 32'(out100), 32'd156);
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 1, 0, 2);
    checkOutput("s100_dn2", 32'(out100), 32'd56);
    checkOutput("s100_not_muted", 32'(muted100), 32'h0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("s100_muted", 32'(muted100), 32'h1);
    applyStimulus(1, 1, 0, 2);
    checkOutput("s100_dn3_zero", 32'(out100), 32'd0);

    // Unit step: ramp to 100, then mute coincident with a tick
    applyStimulus(0, 0, 1, 100);
    applyStimulus(0, 0, 0, 2);
    checkOutput("up_100", 32'(out1), 32'd100);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 2);
    checkOutput("coincide_101", 32'(out1), 32'd101);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 2);
    checkOutput("down_100", 32'(out1), 32'd100);
    applyStimulus(0, 1, 1, 99);
    applyStimulus(0, 1, 0, 2);
    checkOutput("down_1", 32'(out1), 32'd1);
    checkOutput("down_1_not_muted", 32'(muted1), 32'h0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("down_0_muted", 32'(muted1), 32'h1);
    applyStimulus(0, 1, 0, 2);
    checkOutput("down_0_out", 32'(out1), 32'd0);

    // Gain 0: u = 0x8000, dac_bit at exactly half density
    applyStimulus(0, 1, 0, 4);
    countDac(0, 16, cnt);
    checkOutput("half_density", 32'(cnt), 32'd8);

    // Full ramp with in = 0x4000, tick every second cycle
    inSample = 16'h4000;
    applyStimulus(0, 0, 0, 1);
    checkOutput("unmute_ramp_up", 32'(muted1), 32'h0);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1);
    end
    applyStimulus(0, 0, 0, 2);
    checkOutput("gain_255_out", 32'(out1), 32'h3FC0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 2);
    checkOutput("play_out", 32'(out1), 32'h4000);
    applyStimulus(0, 0, 1, 3);
    applyStimulus(0, 0, 0, 2);
    checkOutput("play_sat_out", 32'(out1), 32'h4000);

    // u = 0xC000: 3 carries every 4 cycles
    countDac(0, 4096, cnt);
    checkOutput("density_3_4", 32'(cnt), 32'd3072);

    // Most negative sample: u = 0, bitstream stays low
    inSample = 16'h8000;
    applyStimulus(0, 0, 0, 3);
    checkOutput("neg_full_out", 32'(out1), 32'h8000);
    applyStimulus(0, 0, 0, 2);
    countDac(0, 64, cnt);
    checkOutput("neg_full_dac", 32'(cnt), 32'd0);

    // Sample register holds while the load strobe is low
    en3 = 1'b0;
    inSample = 16'h1234;
    applyStimulus(0, 0, 0, 3);
    checkOutput("hold_out", 32'(out1), 32'h8000);
    en3 = 1'b1;
    applyStimulus(0, 0, 0, 1);
    en3 = 1'b0;
    inSample = 16'h5678;
    applyStimulus(0, 0, 0, 3);
    checkOutput("load_once_out", 32'(out1), 32'h1234);
    en3 = 1'b1;

    // Ramp down to gain 77, then check signed scaling at that gain
    inSample = 16'h0100;
    applyStimulus(0, 0, 0, 2);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 1, 179);
    applyStimulus(0, 1, 0, 2);
    checkOutput("gain_77", 32'(out1), 32'd77);
    inSample = 16'hFF00;
    applyStimulus(0, 1, 0, 3);
    checkOutput("scale_neg256", 32'(out1), 32'hFFB3);
    inSample = 16'h8001;
    applyStimulus(0, 1, 0, 3);
    checkOutput("scale_8001", 32'(out1), 32'hD980);
    inSample = 16'h7FFF;
    applyStimulus(0, 1, 0, 3);
    checkOutput("scale_7fff", 32'(out1), 32'h267F);

    // Reset mid-ramp with a coincident tick
    rst = 1'b1;
    applyStimulus(0, 1, 1, 1);
    checkOutput("midrst_out", 32'(out1), 32'h0);
    checkOutput("midrst_dac", 32'(dac1), 32'h0);
    checkOutput("midrst_muted", 32'(muted1), 32'h1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("rerelease_ramp_up", 32'(muted1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/audio_sd_dac.md
AUDIO_SD_DAC -- requirements
Module: audio_sd_dac

Interface
REQ-001 The block SHALL have parameter RAMP_STEP, default 1, gain increment/decrement per ramp tick (legal 1..256).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port clk_3MHz_en, input, 1, single-cycle sample-load strobe.
REQ-005 The block SHALL have port clk_12KHz_en, input, 1, single-cycle ramp tick strobe.
REQ-006 The block SHALL have port mute, input, 1, request silence (driven from inverted sound enable).
REQ-007 The block SHALL have port in, input, 16, signed mixed audio sample from the mixer stage.
REQ-008 The block SHALL have port sample_out, output, 16, signed gain-scaled sample (HDMI/I2S path).
REQ-009 The block SHALL have port dac_bit, output, 1, first-order sigma-delta bitstream for the pin DAC.
REQ-010 The block SHALL have port muted, output, 1, high only while state is MUTED.

Function
REQ-011 The block SHALL latch in into sample_reg on every clk edge where clk_3MHz_en is high, and hold it otherwise.
REQ-012 The block SHALL keep a 9-bit gain register, range 0..256, where 256 is unity.
REQ-013 The block SHALL implement states MUTED, RAMP_UP, PLAY, RAMP_DOWN, with transitions evaluated every clk.
REQ-014 MUTED: gain held at 0; mute low -> RAMP_UP.
REQ-015 RAMP_UP: on clk_12KHz_en, gain = min(gain+RAMP_STEP, 256); when the updated gain equals 256 -> PLAY; mute high (any cycle) -> RAMP_DOWN without gain jump.
REQ-016 PLAY: gain held at 256; mute high -> RAMP_DOWN.
REQ-017 RAMP_DOWN: on clk_12KHz_en, gain = max(gain-RAMP_STEP, 0); when the updated gain equals 0 -> MUTED; mute low (any cycle) -> RAMP_UP without gain jump.
REQ-018 When a ramp tick and a mute-driven direction change coincide, the gain step SHALL use the direction of the current (pre-edge) state; the new state takes effect on the next cycle.
REQ-019 Gain SHALL saturate, never wrap, at 0 and 256.
REQ-020 The block SHALL compute scaled = (sample_reg * gain) arithmetic-shifted right by 8, as a signed 25-bit product truncated to 16 bits (no overflow possible since gain <= 256).
REQ-021 sample_out SHALL register scaled every clk, giving one cycle latency from sample_reg/gain to sample_out.
REQ-022 The block SHALL form u = sample_out with MSB inverted (offset binary, 0x8000 = silence).
REQ-023 The block SHALL update a 17-bit accumulator every clk as acc = {1'b0, acc[15:0]} + u, and register dac_bit = carry bit acc[16].
REQ-024 The long-run density of dac_bit SHALL equal u/65536 within 1 LSB over any 65536-cycle window of constant u.
REQ-025 With gain 0, sample_out SHALL be 0 and dac_bit SHALL toggle at 50% density (u = 0x8000).
REQ-026 muted SHALL be a registered decode of state, asserted in the same cycle the state register equals MUTED.

Reset
REQ-027 While rst is high the block SHALL set state MUTED, gain 0, sample_reg 0, sample_out 0, acc 0, dac_bit 0, muted 1.
REQ-028 Reset asserted mid-ramp SHALL take priority over all strobes and return every register to REQ-027 values on that edge.
REQ-029 After rst deasserts with mute low, the block SHALL enter RAMP_UP on the first clk edge.

Verification
REQ-030 Reset, mute=0, in=0x4000, tick every 256 clk, RAMP_STEP=1 -> PLAY after 256 ticks; sample_out then 0x4000; muted falls one cycle after rst release.
REQ-031 In PLAY with in=0x8000 (-32768), RAMP_STEP=1 -> sample_out 0x8000; dac_bit constant 0 after accumulator settles.
REQ-032 In RAMP_UP at gain 100, raise mute coincident with a tick -> gain 101 on that edge, RAMP_DOWN next cycle, then 100, 99 ... to 0 -> MUTED.
REQ-033 RAMP_STEP=100, ramping up from 0 -> gain 100, 200, 256 (saturated) -> PLAY; down -> 156, 56, 0 -> MUTED.
REQ-034 PLAY with in=0x4000 held 65536 clk -> dac_bit count 49152 +/- 1.
REQ-035 Assert rst in RAMP_DOWN at gain 77 -> next cycle gain 0, sample_out 0, dac_bit 0, muted 1.
